cmd_seq_player: RTL

//  Synthesizable, parametrised command sequencer for the LA command link: fetches a script of

---
 rtl/la_cmd_pkg.sv | 56 +++++
 rtl/cmd_seq_player_rsp_timer.sv | 49 ++++
 rtl/cmd_seq_player.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/la_cmd_pkg.sv
// -----------------------------------------------------------------------------
// la_cmd_pkg
// Shared types and constants for the LA command-link script player.
//   op_t       : script/command opcode held in word bits [15:14]
//   err_code_t : failure reason reported by cmd_seq_player
//   state_t    : sequencer FSM states
// Script word layout: {op[15:14], field[13:8], data[7:0]}. A DUMP takes its
// channel number from field[2:0], which is word bits [10:8].
// -----------------------------------------------------------------------------
package la_cmd_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_DUMP  = 2'b10,
        OP_END   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ERR_MISMATCH = 2'd0,
        ERR_NAK      = 2'd1,
        ERR_BADCH    = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_code_t;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_ISSUE    = 4'd3,
        ST_WAIT_TX  = 4'd4,
        ST_WAIT_RSP = 4'd5,
        ST_DUMP_RX  = 4'd6,
        ST_DONE     = 4'd7,
        ST_ERROR    = 4'd8
    } state_t;

    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NCK = 8'hEE;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 14;
    localparam int CH_MSB = 10;
    localparam int CH_LSB = 8;

    // Opcode of a script word.
    function automatic op_t word_op(input logic [15:0] w);
        return op_t'(w[OP_MSB:OP_LSB]);
    endfunction

    // DUMP channel number of a script word.
    function automatic logic [2:0] word_chan(input logic [15:0] w);
        return w[CH_MSB:CH_LSB];
    endfunction

endpackage

// File: rtl/cmd_seq_player_rsp_timer.sv
// -----------------------------------------------------------------------------
// rsp_timer
// Response watchdog. It counts enabled cycles and saturates at TIMEOUT.
// expired is registered and goes high in the cycle where the count equals TIMEOUT.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : restart the count (has priority over en)
//   en         : count this cycle
//   expired    : count has reached TIMEOUT
// -----------------------------------------------------------------------------
module rsp_timer #(
    parameter  int TIMEOUT = 65535,
    localparam int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    logic [TW-1:0] cnt_r;
    logic [TW-1:0] cnt_nxt_s;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = '0;
        end else if (en && (cnt_r != TMAX)) begin
            cnt_nxt_s = cnt_r + TW'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register and registered expiry flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            expired <= 1'b0;
        end else begin
            cnt_r   <= cnt_nxt_s;
            expired <= (cnt_nxt_s == TMAX);
        end
    end

endmodule

// File: rtl/cmd_seq_player.sv
// -----------------------------------------------------------------------------
// cmd_seq_player
// Runs a READ/WRITE/DUMP/END script from a synchronous ROM. It drives
// CommMaster, checks the replies, and streams DUMP bytes out.
// Optional feature: define CMDSEQ_EXPECT_EN to make each READ compare the
// reply with the entry's data byte. A difference gives ERROR code 0.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   start                   : pulse that runs the script from entry 0 (ignored while busy)
//   scr_addr / scr_data     : script ROM address / word (valid 1 clk later)
//   cmd, snd_cmd, cmd_cmplt : CommMaster command, send pulse, transmit complete
//   rec_data, rec_rdy       : received byte and its level-valid flag
//   clr_rec_rdy             : pulse that acknowledges the received byte
//   rd_data, rd_vld         : READ result and its 1-clk strobe
//   dump_byte, dump_vld     : DUMP sample and its 1-clk strobe
//   busy, done, err         : status flags
//   err_idx, err_code       : entry that failed and the reason
// -----------------------------------------------------------------------------
module cmd_seq_player
    import la_cmd_pkg::*;
#(
    parameter  int NUM_CH       = 5,
    parameter  int ENTRIES      = 384,
    parameter  int SCRIPT_DEPTH = 64,
    parameter  int TIMEOUT      = 65535,
    localparam int SAW          = $clog2(SCRIPT_DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic [SAW-1:0] scr_addr,
    input  logic [15:0]    scr_data,
    output logic [15:0]    cmd,
    output logic           snd_cmd,
    input  logic           cmd_cmplt,
    input  logic [7:0]     rec_data,
    input  logic           rec_rdy,
    output logic           clr_rec_rdy,
    output logic [7:0]     rd_data,
    output logic           rd_vld,
    output logic [7:0]     dump_byte,
    output logic           dump_vld,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [SAW-1:0] err_idx,
    output logic [1:0]     err_code
);

    localparam int              CW        = $clog2(ENTRIES + 1);
    localparam logic [CW-1:0]   LAST_BYTE = CW'(ENTRIES - 1);
    localparam logic [SAW-1:0]  LAST_IDX  = SAW'(SCRIPT_DEPTH - 1);

    state_t         state_r;
    logic [SAW-1:0] idx_r;
    logic [CW-1:0]  byte_cnt_r;
    logic           tmr_clr_s;
    logic           tmr_en_s;
    logic           tmr_expired_s;
    logic           byte_take_s;

    rsp_timer #(.TIMEOUT(TIMEOUT)) u_rsp_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr_s),
        .en      (tmr_en_s),
        .expired (tmr_expired_s)
    );

    // Byte acceptance and watchdog control. No byte is taken in the cycle
    // right after a clear, because rec_rdy has not dropped yet at that point.
    always_comb begin
        tmr_en_s    = 1'b0;
        byte_take_s = 1'b0;
        case (state_r)
            ST_WAIT_TX: begin
                tmr_en_s = 1'b1;
            end
            ST_WAIT_RSP, ST_DUMP_RX: begin
                tmr_en_s    = 1'b1;
                byte_take_s = rec_rdy & ~clr_rec_rdy;
            end
            default: begin
                tmr_en_s    = 1'b0;
                byte_take_s = 1'b0;
            end
        endcase
        tmr_clr_s = (state_r == ST_ISSUE) | byte_take_s;
    end

    // Sequencer FSM. All outputs are registered. Strobes default low each cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            byte_cnt_r  <= '0;
            scr_addr    <= '0;
            cmd         <= 16'h0000;
            snd_cmd     <= 1'b0;
            clr_rec_rdy <= 1'b0;
            rd_data     <= 8'h00;
            rd_vld      <= 1'b0;
            dump_byte   <= 8'h00;
            dump_vld    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_idx     <= '0;
            err_code    <= 2'd0;
        end else begin
            snd_cmd     <= 1'b0;
            clr_rec_rdy <= 1'b0;
            rd_vld      <= 1'b0;
            dump_vld    <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        idx_r    <= '0;
                        scr_addr <= '0;
                        state_r  <= ST_FETCH;
                    end else begin
                        state_r  <= state_r;
                    end
                end
                // The ROM is registered, so wait one cycle for scr_data.
                ST_FETCH: begin
                    state_r <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (word_op(scr_data) == OP_END) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_DONE;
                    end else if ((word_op(scr_data) == OP_DUMP) &&
                                 ((word_chan(scr_data) == 3'd0) ||
                                  (int'(word_chan(scr_data)) > NUM_CH))) begin
                        err      <= 1'b1;
                        busy     <= 1'b0;
                        err_idx  <= idx_r;
                        err_code <= ERR_BADCH;
                        state_r  <= ST_ERROR;
                    end else begin
                        cmd     <= scr_data;
                        snd_cmd <= 1'b1;
                        state_r <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (cmd_cmplt) begin
                        byte_cnt_r <= '0;
                        state_r    <= (word_op(cmd) == OP_DUMP) ? ST_DUMP_RX : ST_WAIT_RSP;
                    end else if (tmr_expired_s) begin
                        err      <= 1'b1;
                        busy     <= 1'b0;
                        err_idx  <= idx_r;
                        err_code <= ERR_TIMEOUT;
                        state_r  <= ST_ERROR;
                    end else begin
                        state_r  <= ST_WAIT_TX;
                    end
                end
                ST_WAIT_RSP: begin
                    if (byte_take_s) begin
                        clr_rec_rdy <= 1'b1;
                        if (word_op(cmd) == OP_READ) begin
                            rd_data <= rec_data;
                            rd_vld  <= 1'b1;
                        end else begin
                            rd_vld  <= 1'b0;
                        end
`ifdef CMDSEQ_EXPECT_EN
                        if ((word_op(cmd) == OP_READ) && (rec_data != cmd[7:0])) begin
                            err      <= 1'b1;
                            busy     <= 1'b0;
                            err_idx  <= idx_r;
                            err_code <= ERR_MISMATCH;
                            state_r  <= ST_ERROR;
                        end else
`endif
                        if ((word_op(cmd) == OP_WRITE) && (rec_data != ACK)) begin
                            err      <= 1'b1;
                            busy     <= 1'b0;
                            err_idx  <= idx_r;
                            err_code <= ERR_NAK;
                            state_r  <= ST_ERROR;
                        end else if (idx_r == LAST_IDX) begin
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state_r  <= ST_DONE;
                        end else begin
                            idx_r    <= idx_r + SAW'(1);
                            scr_addr <= idx_r + SAW'(1);
                            state_r  <= ST_FETCH;
                        end
                    end else if (tmr_expired_s) begin
                        err      <= 1'b1;
                        busy     <= 1'b0;
                        err_idx  <= idx_r;
                        err_code <= ERR_TIMEOUT;
                        state_r  <= ST_ERROR;
                    end else begin
                        state_r  <= ST_WAIT_RSP;
                    end
                end
                ST_DUMP_RX: begin
                    if (byte_take_s) begin
                        dump_byte   <= rec_data;
                        dump_vld    <= 1'b1;
                        clr_rec_rdy <= 1'b1;
                        byte_cnt_r  <= byte_cnt_r + CW'(1);
                        if (byte_cnt_r != LAST_BYTE) begin
                            state_r  <= ST_DUMP_RX;
                        end else if (idx_r == LAST_IDX) begin
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state_r  <= ST_DONE;
                        end else begin
                            idx_r    <= idx_r + SAW'(1);
                            scr_addr <= idx_r + SAW'(1);
                            state_r  <= ST_FETCH;
                        end
                    end else if (tmr_expired_s) begin
                        err      <= 1'b1;
                        busy     <= 1'b0;
                        err_idx  <= idx_r;
                        err_code <= ERR_TIMEOUT;
                        state_r  <= ST_ERROR;
                    end else begin
                        state_r  <= ST_DUMP_RX;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
